// File: rtl/screen_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : screen_scanner                                                |
// | Purpose  : Scans the 1 bpp framebuffer through an arbitrated byte read   |
// |            port and streams it row-major as pixels over valid/ready.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module screen_scanner #(
  parameter logic [11:0] SCREEN_BASE = 12'h100,
  parameter int          WIDTH       = 64,
  parameter int          HEIGHT      = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_start,
  output logic                        mem_req,
  output logic [11:0]                 mem_addr,
  input  logic                        mem_gnt,
  input  logic [7:0]                  mem_rd_data,
  output logic                        px_valid,
  input  logic                        px_ready,
  output logic                        px_data,
  output logic [$clog2(WIDTH)-1:0]    px_x,
  output logic [$clog2(HEIGHT)-1:0]   px_y,
  output logic                        px_sof,
  output logic                        px_eol,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        frame_overrun
);

  localparam int XW     = $clog2(WIDTH);
  localparam int YW     = $clog2(HEIGHT);
  localparam int NBYTES = WIDTH * HEIGHT / 8;
  localparam int BW     = $clog2(NBYTES);

  localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_READ  = 2'd2,
    S_SHIFT = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   byte_idx, byte_nxt;
  logic [2:0]      bit_idx, bit_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic            done_nxt;
  logic            overrun_nxt;

  // Linear pixel index; because WIDTH is a power of two the low bits are the
  // column and the high bits the row, whatever the byte-per-row count is.
  logic [XW+YW-1:0] pix_idx;
  assign pix_idx = {byte_idx, bit_idx};

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_nxt   = state;
    byte_nxt    = byte_idx;
    bit_nxt     = bit_idx;
    shreg_nxt   = shreg;
    done_nxt    = 1'b0;
    overrun_nxt = frame_start && (state != S_IDLE);
    mem_req     = 1'b0;
    px_valid    = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_start) begin
          byte_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        // Request and address stay put until the arbiter grants.
        mem_req = 1'b1;
        if (mem_gnt) begin
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        // Read data returns exactly one cycle after the grant.
        shreg_nxt = mem_rd_data;
        bit_nxt   = '0;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        px_valid = 1'b1;
        if (px_ready) begin
          shreg_nxt = {shreg[6:0], 1'b0};
          bit_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            if (byte_idx == BYTE_LAST) begin
              done_nxt  = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              byte_nxt  = byte_idx + BW'(1);
              state_nxt = S_REQ;
            end
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      byte_idx      <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      state         <= state_nxt;
      byte_idx      <= byte_nxt;
      bit_idx       <= bit_nxt;
      shreg         <= shreg_nxt;
      frame_done    <= done_nxt;
      frame_overrun <= overrun_nxt;
    end
  end

  // Pixel fields are forced to zero whenever no pixel is being presented.
  assign mem_addr = mem_req ? (SCREEN_BASE + 12'(byte_idx)) : 12'h000;
  assign px_data  = px_valid & shreg[7];
  assign px_x     = px_valid ? pix_idx[XW-1:0] : '0;
  assign px_y     = px_valid ? pix_idx[XW+YW-1:XW] : '0;
  assign px_sof   = px_valid && (pix_idx == '0);
  assign px_eol   = px_valid && (pix_idx[XW-1:0] == X_LAST);
  assign busy     = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_screen_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_screen_scanner                                             |
// | Purpose  : Randomized scoreboard bench for screen_scanner.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_screen_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_gnt;
  logic [7:0]  mem_rd_data;
  logic        px_valid;
  logic        px_ready;
  logic        px_data;
  logic [5:0]  px_x;
  logic [4:0]  px_y;
  logic        px_sof;
  logic        px_eol;
  logic        busy;
  logic        frame_done;
  logic        frame_overrun;

  screen_scanner dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rd_data(mem_rd_data), .px_valid(px_valid), .px_ready(px_ready),
    .px_data(px_data), .px_x(px_x), .px_y(px_y), .px_sof(px_sof),
    .px_eol(px_eol), .busy(busy), .frame_done(frame_done),
    .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       data;
    logic [5:0] x;
    logic [4:0] y;
    logic       sof;
    logic       eol;
  } px_t;

  px_t        sb[$];
  logic [7:0] mem [0:4095];
  int checks = 0, errors = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0;
  int acc_cnt = 0, done_cnt = 0, sof_cnt = 0, eol_cnt = 0, ovr_cnt = 0;
  bit ready_rand = 1'b0;
  int gnt_mode = 1;  // 0 low, 1 high, 2 random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: every pixel of the screen, row-major, from the byte image.
  task automatic push_frame();
    for (int y = 0; y < 32; y++) begin
      for (int x = 0; x < 64; x++) begin
        logic [7:0] b;
        px_t p;
        b      = mem[12'h100 + y * 8 + x / 8];
        p.data = b[7 - (x % 8)];
        p.x    = 6'(x);
        p.y    = 5'(y);
        p.sof  = (x == 0) && (y == 0);
        p.eol  = (x == 63);
        sb.push_back(p);
      end
    end
  endtask

  task automatic fill_fb(input bit random_fill);
    for (int i = 0; i < 256; i++) mem[12'h100 + i] = random_fill ? 8'($urandom) : 8'h00;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory behind the arbiter: data one cycle after req&gnt, junk otherwise.
  always @(posedge clk) begin
    if (mem_req && mem_gnt) mem_rd_data <= mem[mem_addr];
    else                    mem_rd_data <= 8'($urandom);
  end

  // Consumer ready and arbiter grant drivers.
  initial begin
    px_ready = 1'b0;
    mem_gnt  = 1'b0;
    forever begin
      @(posedge clk); #1;
      px_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      case (gnt_mode)
        0:       mem_gnt = 1'b0;
        1:       mem_gnt = 1'b1;
        default: mem_gnt = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops expected pixels on handshakes, checks stall/request holds.
  px_t         held;
  px_t         cur;
  px_t         expv;
  logic [11:0] held_addr;
  bit          stalled = 1'b0;
  bit          req_wait = 1'b0;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      stalled  = 1'b0;
      req_wait = 1'b0;
    end else begin
      cur = '{px_data, px_x, px_y, px_sof, px_eol};
      if (stalled) begin
        chk("stall_valid", 32'(px_valid), 32'd1);
        chk("stall_hold", 32'(cur), 32'(held));
      end
      if (req_wait) begin
        chk("req_hold", 32'(mem_req), 32'd1);
        chk("addr_hold", 32'(mem_addr), 32'(held_addr));
      end
      if (px_valid && px_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_pixel", 32'(cur), 32'hFFFF_FFFF);
        end else begin
          expv = sb.pop_front();
          chk("pixel", 32'(cur), 32'(expv));
        end
        acc_cnt++;
        if (px_sof) sof_cnt++;
        if (px_eol) eol_cnt++;
      end
      stalled   = px_valid && !px_ready;
      held      = cur;
      req_wait  = mem_req && !mem_gnt;
      held_addr = mem_addr;
      if (frame_overrun) ovr_cnt++;
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_after_last_px", 32'(sb.size()), 32'd0);
      end
    end
  end

  task automatic start_frame(input bit expect_accept);
    @(posedge clk); #1;
    if (expect_accept) begin
      push_frame();
      start_cyc = cyc + 1;
    end
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int budget, input string name);
    int k = 0;
    while (done_cnt == n0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    chk(name, 32'(done_cnt), 32'(n0 + 1));
  endtask

  task automatic wait_pixels(input int target);
    int k = 0;
    while (acc_cnt < target && k < 20000) begin
      @(posedge clk);
      k++;
    end
    chk("reach_pixel", 32'(acc_cnt >= target), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  int d0, a0, s0, e0;
  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({mem_req, mem_addr, px_valid, px_data, px_x, px_y,
                              px_sof, px_eol, busy, frame_done, frame_overrun}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: blank screen, full throughput, exact frame latency
    d0 = done_cnt; a0 = acc_cnt; s0 = sof_cnt; e0 = eol_cnt;
    start_frame(1'b1);
    wait_done(d0, 4000, "t1_done");
    chk("t1_latency", 32'(done_cyc - start_cyc), 32'd2560);
    chk("t1_pixels", 32'(acc_cnt - a0), 32'd2048);
    chk("t1_sof", 32'(sof_cnt - s0), 32'd1);
    chk("t1_eol", 32'(eol_cnt - e0), 32'd32);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t1_single_done", 32'(done_cnt), 32'(d0 + 1));
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: corner pixels
    fill_fb(1'b0);
    mem[12'h100] = 8'h80;
    mem[12'h1FF] = 8'h01;
    d0 = done_cnt;
    start_frame(1'b1);
    wait_done(d0, 4000, "t2_done");

    // 3: random image with 0xA5 in row 1, random back-pressure
    fill_fb(1'b1);
    mem[12'h108] = 8'hA5;
    ready_rand = 1'b1;
    d0 = done_cnt;
    start_frame(1'b1);
    wait_done(d0, 12000, "t3_done");
    ready_rand = 1'b0;

    // 4: grant withheld for 20 cycles after start
    fill_fb(1'b1);
    gnt_mode = 0;
    d0 = done_cnt;
    start_frame(1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t4_req", 32'(mem_req), 32'd1);
      chk("t4_addr", 32'(mem_addr), 32'h100);
      chk("t4_no_px", 32'(px_valid), 32'd0);
    end
    gnt_mode = 1;
    wait_done(d0, 4000, "t4_done");

    // 5: frame_start mid-frame raises overrun, frame unaffected
    fill_fb(1'b1);
    gnt_mode = 2;
    d0 = done_cnt; a0 = acc_cnt;
    start_frame(1'b1);
    wait_pixels(a0 + 500);
    start_frame(1'b0);
    @(negedge clk);
    chk("t5_overrun", 32'(frame_overrun), 32'd1);
    @(negedge clk);
    chk("t5_overrun_pulse", 32'(frame_overrun), 32'd0);
    wait_done(d0, 12000, "t5_done");
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("t5_single_done", 32'(done_cnt), 32'(d0 + 1));
    chk("t5_overrun_count", 32'(ovr_cnt), 32'd1);
    gnt_mode = 1;

    // 6: reset mid-frame abandons the frame
    fill_fb(1'b1);
    ready_rand = 1'b1;
    d0 = done_cnt; a0 = acc_cnt;
    start_frame(1'b1);
    wait_pixels(a0 + 100);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_px_valid", 32'(px_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_mem_req", 32'(mem_req), 32'd0);
    repeat (3000) @(posedge clk);
    @(negedge clk);
    chk("t6_no_done", 32'(done_cnt), 32'(d0));
    s0 = sof_cnt;
    start_frame(1'b1);
    wait_done(d0, 12000, "t6_restart_done");
    chk("t6_sof", 32'(sof_cnt - s0), 32'd1);
    ready_rand = 1'b0;

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("final_queue_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
